// File: rtl/chat_buffer_ctrl.sv
// Chat screen sequencing controller: edits the keyboard input line, hands completed
// lines to the transmitter over valid/ready, and keeps the outgoing/incoming histories.
module chat_buffer_ctrl #(
  parameter int NCHAR  = 16,
  parameter int NLINES = 5
) (
  input  logic                      clock_65mhz,
  input  logic                      reset,
  input  logic                      key_valid,
  input  logic [7:0]                key_ascii,
  input  logic                      rx_valid,
  input  logic [NCHAR*8-1:0]        rx_line,
  input  logic                      tx_ready,
  output logic                      tx_valid,
  output logic [NCHAR*8-1:0]        tx_line,
  output logic [NCHAR*8-1:0]        keyboard,
  output logic [4:0]                input_len,
  output logic [NCHAR*8*NLINES-1:0] messageout,
  output logic [NCHAR*8*NLINES-1:0] messagein,
  output logic                      key_drop
);

  localparam int LW = NCHAR * 8;
  localparam int HW = LW * NLINES;
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [LW-1:0] BLANK_LINE = {NCHAR{BLANK}};

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [LW-1:0] kb_r, kb_s;
  logic [LW-1:0] txl_r, txl_s;
  logic [4:0]    len_r, len_s;
  logic          txv_r, txv_s;
  logic          drop_r, drop_s;
  logic [HW-1:0] mout_r, mout_s;
  logic [HW-1:0] min_r, min_s;
  logic          handshake_s;
  logic          printable_s;

  // Newest line enters the top slot; slot 0 (oldest) is discarded.
  function automatic logic [HW-1:0] push_line(input logic [HW-1:0] hist,
                                               input logic [LW-1:0] line);
    return {line, hist[HW-1:LW]};
  endfunction

  // Next-state logic; the handshake is resolved first so a same-cycle key sees pre-edge state.
  always_comb begin
    state_s     = state_r;
    kb_s        = kb_r;
    txl_s       = txl_r;
    len_s       = len_r;
    txv_s       = txv_r;
    drop_s      = 1'b0;
    mout_s      = mout_r;
    min_s       = min_r;
    handshake_s = (state_r == SEND) && tx_ready;
    printable_s = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

    if (handshake_s) begin
      mout_s  = push_line(mout_r, txl_r);
      txv_s   = 1'b0;
      state_s = IDLE;
    end else begin
      mout_s = mout_r;
    end

    if (rx_valid) begin
      min_s = push_line(min_r, rx_line);
    end else begin
      min_s = min_r;
    end

    if (key_valid) begin
      if (printable_s) begin
        if (len_r < 5'(NCHAR)) begin
          kb_s[LW-8-8*int'(len_r) +: 8] = key_ascii;
          len_s = len_r + 5'd1;
        end else begin
          drop_s = 1'b1;
        end
      end else if (key_ascii == 8'h08) begin
        if (len_r != 5'd0) begin
          kb_s[LW-8*int'(len_r) +: 8] = BLANK;
          len_s = len_r - 5'd1;
        end else begin
          len_s = len_r;
        end
      end else if (key_ascii == 8'h0D) begin
        if (len_r == 5'd0) begin
          drop_s = 1'b0;
        end else if (state_r == SEND) begin
          drop_s = 1'b1;
        end else begin
          txl_s   = kb_r;
          txv_s   = 1'b1;
          kb_s    = BLANK_LINE;
          len_s   = 5'd0;
          state_s = SEND;
        end
      end else begin
        drop_s = 1'b0;
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  // State and output registers; reset overrides every concurrent strobe.
  always_ff @(posedge clock_65mhz) begin
    if (reset) begin
      state_r <= IDLE;
      kb_r    <= BLANK_LINE;
      txl_r   <= BLANK_LINE;
      len_r   <= 5'd0;
      txv_r   <= 1'b0;
      drop_r  <= 1'b0;
      mout_r  <= {NLINES{BLANK_LINE}};
      min_r   <= {NLINES{BLANK_LINE}};
    end else begin
      state_r <= state_s;
      kb_r    <= kb_s;
      txl_r   <= txl_s;
      len_r   <= len_s;
      txv_r   <= txv_s;
      drop_r  <= drop_s;
      mout_r  <= mout_s;
      min_r   <= min_s;
    end
  end

  assign tx_valid   = txv_r;
  assign tx_line    = txl_r;
  assign keyboard   = kb_r;
  assign input_len  = len_r;
  assign messageout = mout_r;
  assign messagein  = min_r;
  assign key_drop   = drop_r;

endmodule

// File: tb/tb_chat_buffer_ctrl.sv
// Scoreboard bench for chat_buffer_ctrl: directed stimulus pushes hand-computed expected
// snapshots; a negedge monitor pops and compares them, plus every transmitted line.
module tb_chat_buffer_ctrl;

  localparam int NCHAR  = 16;
  localparam int NLINES = 5;

  logic         clk;
  logic         reset;
  logic         key_valid;
  logic [7:0]   key_ascii;
  logic         rx_valid;
  logic [127:0] rx_line;
  logic         tx_ready;
  logic         tx_valid;
  logic [127:0] tx_line;
  logic [127:0] keyboard;
  logic [4:0]   input_len;
  logic [639:0] messageout;
  logic [639:0] messagein;
  logic         key_drop;

  chat_buffer_ctrl #(.NCHAR(NCHAR), .NLINES(NLINES)) dut (
    .clock_65mhz(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_ascii(key_ascii),
    .rx_valid(rx_valid),
    .rx_line(rx_line),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_line(tx_line),
    .keyboard(keyboard),
    .input_len(input_len),
    .messageout(messageout),
    .messagein(messagein),
    .key_drop(key_drop)
  );

  typedef struct packed {
    logic [127:0] kb;
    logic [4:0]   len;
    logic         drop;
    logic         txv;
    logic [127:0] txl;
    logic [639:0] mo;
    logic [639:0] mi;
  } exp_t;

  exp_t         sb[$];
  string        sb_name[$];
  logic [127:0] tx_exp[$];

  int checks = 0;
  int errors = 0;

  logic [127:0] e_kb, e_txl;
  logic [4:0]   e_len;
  logic         e_drop, e_txv;
  logic [639:0] e_mo, e_mi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input string s);
    logic [127:0] r;
    r = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [639:0] hist(input string s0, input string s1, input string s2,
                                        input string s3, input string s4);
    return {line_of(s4), line_of(s3), line_of(s2), line_of(s1), line_of(s0)};
  endfunction

  task automatic cmp(input string nm, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_st(input string nm);
    exp_t r;
    r.kb = e_kb; r.len = e_len; r.drop = e_drop; r.txv = e_txv;
    r.txl = e_txl; r.mo = e_mo; r.mi = e_mi;
    sb.push_back(r);
    sb_name.push_back(nm);
  endtask

  // Monitor: transmitted lines on each handshake, then any pending state snapshot.
  always @(negedge clk) begin
    exp_t  r;
    string nm;
    if (tx_valid && tx_ready && !reset) begin
      if (tx_exp.size() == 0) begin
        cmp("tx_unexpected", 640'(tx_line), 640'(0));
      end else begin
        cmp("tx_line_sent", 640'(tx_line), 640'(tx_exp.pop_front()));
      end
    end
    while (sb.size() > 0) begin
      r  = sb.pop_front();
      nm = sb_name.pop_front();
      cmp({nm, "_keyboard"}, 640'(keyboard), 640'(r.kb));
      cmp({nm, "_len"}, 640'(input_len), 640'(r.len));
      cmp({nm, "_drop"}, 640'(key_drop), 640'(r.drop));
      cmp({nm, "_txv"}, 640'(tx_valid), 640'(r.txv));
      if (r.txv) cmp({nm, "_txline"}, 640'(tx_line), 640'(r.txl));
      cmp({nm, "_msgout"}, messageout, r.mo);
      cmp({nm, "_msgin"}, messagein, r.mi);
    end
  end

  task automatic tick(input logic kv, input logic [7:0] ka, input logic rv, input logic [127:0] rl);
    key_valid = kv; key_ascii = ka; rx_valid = rv; rx_line = rl;
    @(posedge clk);
    #1;
    key_valid = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic key(input logic [7:0] c);
    tick(1'b1, c, 1'b0, line_of(""));
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 1'b0, line_of(""));
  endtask

  task automatic set_reset_exp();
    e_kb = line_of(""); e_len = 5'd0; e_drop = 1'b0; e_txv = 1'b0; e_txl = line_of("");
    e_mo = hist("", "", "", "", ""); e_mi = hist("", "", "", "", "");
  endtask

  task automatic do_reset(input logic with_strobes);
    reset = 1'b1;
    key_valid = with_strobes; key_ascii = 8'h0D;
    rx_valid = with_strobes; rx_line = line_of("RST");
    @(posedge clk);
    #1;
    reset = 1'b0; key_valid = 1'b0; rx_valid = 1'b0;
    set_reset_exp();
    expect_st("reset");
  endtask

  initial begin
    string s;
    reset = 1'b1; key_valid = 1'b0; key_ascii = 8'h00;
    rx_valid = 1'b0; rx_line = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_reset_exp();
    expect_st("por");

    // Type "HI"
    key(8'h48); e_kb = line_of("H");  e_len = 5'd1; expect_st("type_h");
    key(8'h49); e_kb = line_of("HI"); e_len = 5'd2; expect_st("type_hi");
    idle(); expect_st("hi_hold");

    // 17 printable keys: the last is dropped
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) key(8'(8'h41 + i));
    e_kb = line_of("ABCDEFGHIJKLMNOP"); e_len = 5'd16; expect_st("full");
    key(8'h51); e_drop = 1'b1; expect_st("overflow");
    idle(); e_drop = 1'b0; expect_st("drop_one_cycle");

    // Backspace, silent ignores
    do_reset(1'b0);
    key(8'h41); key(8'h42);
    key(8'h08); e_kb = line_of("A"); e_len = 5'd1; expect_st("bs1");
    key(8'h08); e_kb = line_of("");  e_len = 5'd0; expect_st("bs2");
    key(8'h08); expect_st("bs3_empty");
    key(8'h1B); expect_st("esc_ignored");
    key(8'h0D); expect_st("enter_empty");

    // HELLO, Enter while transmitter stalled
    do_reset(1'b0);
    s = "HELLO";
    for (int i = 0; i < 5; i++) key(s[i]);
    key(8'h0D);
    e_kb = line_of(""); e_len = 5'd0; e_txv = 1'b1; e_txl = line_of("HELLO");
    expect_st("enter");
    for (int i = 0; i < 8; i++) begin
      idle(); expect_st("send_hold");
    end
    key(8'h58); e_kb = line_of("X"); e_len = 5'd1; expect_st("edit_in_send");
    key(8'h0D); e_drop = 1'b1; expect_st("enter_rejected");
    idle(); e_drop = 1'b0; expect_st("reject_clear");
    tx_exp.push_back(line_of("HELLO"));
    tx_ready = 1'b1;
    idle(); e_txv = 1'b0; e_mo = hist("", "", "", "", "HELLO"); expect_st("handshake");
    idle(); expect_st("ready_ignored");

    // RX push, TX handshake and rejected Enter all in one cycle
    tx_ready = 1'b0;
    key(8'h0D);
    e_kb = line_of(""); e_len = 5'd0; e_txv = 1'b1; e_txl = line_of("X");
    expect_st("enter_x");
    key(8'h59); e_kb = line_of("Y"); e_len = 5'd1; expect_st("type_y");
    tx_exp.push_back(line_of("X"));
    tx_ready = 1'b1;
    tick(1'b1, 8'h0D, 1'b1, line_of("R1"));
    e_txv = 1'b0; e_drop = 1'b1;
    e_mo = hist("", "", "", "HELLO", "X"); e_mi = hist("", "", "", "", "R1");
    expect_st("simul");
    tx_ready = 1'b0;

    // Six back-to-back RX lines
    e_drop = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 8'h00, 1'b1, line_of($sformatf("L%0d", i)));
      if (i == 5) begin
        e_mi = hist("L1", "L2", "L3", "L4", "L5"); expect_st("rx5");
      end
      if (i == 6) begin
        e_mi = hist("L2", "L3", "L4", "L5", "L6"); expect_st("rx6");
      end
    end

    // Reset while SEND is pending, with concurrent strobes
    key(8'h5A);
    key(8'h0D);
    e_kb = line_of(""); e_len = 5'd0; e_txv = 1'b1; e_txl = line_of("YZ");
    expect_st("enter_yz");
    do_reset(1'b1);
    tx_ready = 1'b1;
    idle(); expect_st("post_reset_ready");
    tx_ready = 1'b0;
    idle(); idle();

    cmp("scoreboard_drained", 640'(sb.size()), 640'(0));
    cmp("tx_all_sent", 640'(tx_exp.size()), 640'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
